qf_rfm_rd_seq: RTL and testbench
================================

// Module: qf_rfm_rd_seq
// PURPOSE
// - Read-side sequencer for the FCB register-file memory (64b x 16 default). On a start command it sweeps
//   the memory read address over a programmed range and captures each word from the async read port.
// - Each word leaves as PAR_MEMORY_WIDTH_BIT/PAR_BEAT_WIDTH_BIT beats on a valid/ready stream to FCB readback.
// - Sits beside the memory; the write side stays owned by the existing negedge writer.
// PARAMETERS
// - PAR_MEMORY_WIDTH_BIT  64  memory word width; must be an integer multiple of PAR_BEAT_WIDTH_BIT
// - PAR_MEMORY_DEPTH_BIT  4   address width; memory holds 2**PAR_MEMORY_DEPTH_BIT words
// - PAR_BEAT_WIDTH_BIT    32  output stream beat width
// PORTS
// - fcb_sys_clk     in   1      clock; all state updates on posedge
// - fcb_sys_rst_n   in   1      asynchronous active-low reset
// - rdc_start       in   1      1-cycle start request; sampled only in IDLE
// - rdc_start_addr  in   DEPTH  first word address, sampled with rdc_start
// - rdc_word_cnt    in   DEPTH+1  words to read (0..2**DEPTH), sampled with rdc_start
// - rdc_abort       in   1      terminate sweep; has priority over all other events
// - rdc_busy        out  1      high from the cycle after accepted start until return to IDLE
// - rdc_done        out  1      1-cycle pulse on normal completion (not on abort)
// - rfm_rd_addr     out  DEPTH  registered read address to the memory
// - rfm_rd_data     in   WIDTH  async read data from the memory
// - rdc_tx_data     out  BEAT   stream data, least-significant beat of each word first
// - rdc_tx_valid    out  1      stream valid
// - rdc_tx_ready    in   1      stream ready; beat transfers when valid & ready at posedge
// - rdc_tx_last     out  1      high on final beat of final word
// BEHAVIOUR
// - Reset: state=IDLE; rdc_busy=0, rdc_done=0, rfm_rd_addr=0, rdc_tx_data=0, rdc_tx_valid=0, rdc_tx_last=0.
// - FSM IDLE -> FETCH -> SEND -> (FETCH | DONE) -> IDLE.
// - IDLE: rdc_start & rdc_word_cnt!=0 -> FETCH, rfm_rd_addr<=rdc_start_addr, remaining<=rdc_word_cnt.
//   rdc_start & rdc_word_cnt==0 -> DONE (no beats). rdc_start in any other state is ignored.
// - FETCH (1 cycle): capture rfm_rd_data into word buffer, beat index<=0, go SEND; rdc_tx_valid=1 from next cycle.
// - SEND: rdc_tx_data = buffer beat[index]; valid held until handshake; data stable while valid & !ready.
//   On handshake of non-final beat: index++. On final beat of word: remaining--, rfm_rd_addr++ (wraps
//   modulo 2**DEPTH), then FETCH if remaining>1 before decrement, else DONE. Valid deasserts after last beat.
// - Latency: start accepted at cycle N -> first beat valid at N+2; one bubble cycle per word (FETCH).
// - DONE (1 cycle): rdc_done=1, rdc_busy=0 next cycle, return IDLE. rdc_tx_last asserted with final beat only.
// - Abort: in any non-IDLE state, next cycle IDLE, valid/last/busy drop to 0, no rdc_done; in-flight beat lost.
// - Write collision: memory updates on negedge; a word written during FETCH is captured with its new value.
//   Coherency between writer and sweep is the caller's responsibility.
// - Full sweep: rdc_word_cnt=2**DEPTH from any start address reads every word once, address wraps.
// - Reset mid-sweep: immediate return to reset values, no further beats.
// CONFIGURATION
// - QL_RFM_RD_PARITY_EN defined: extra output rdc_tx_par (1b) = even parity (XOR) of rdc_tx_data, same
//   timing as rdc_tx_data, reset 0.
// - Undefined: port absent; no parity logic; all other behaviour identical.
// STRUCTURE
// - Shared package qf_rfm_pkg: rfm_rd_state_e enum {IDLE, FETCH, SEND, DONE}; localparam beats-per-word
//   = PAR_MEMORY_WIDTH_BIT/PAR_BEAT_WIDTH_BIT and its index width.
// - One sub-module: qf_rfm_beat_mux (word buffer + beat select + optional parity), sequencer FSM at top.
// - Elaboration check: WIDTH % BEAT != 0 -> $error.
// TESTING
// - Preload mem[3]=64'hAAAA_BBBB_CCCC_DDDD, start addr=3 cnt=1, ready=1 -> beats 32'hCCCC_DDDD then
//   32'hAAAA_BBBB, last on beat 2, rdc_done one cycle later, first valid 2 cycles after start.
// - Start addr=14 cnt=4, mem[i]=i replicated -> words 14,15,0,1 in order (wrap), 8 beats, one last.
// - Random ready backpressure (50% low) on cnt=16 sweep -> data/valid stable while stalled, 32 beats, no loss.
// - cnt=0 -> no valid, rdc_done pulse 1 cycle after start; start while busy -> ignored, sweep unaffected.
// - Abort during SEND of word 2 of 5 -> valid/busy low next cycle, no rdc_done; new start then runs cleanly.
// - With QL_RFM_RD_PARITY_EN, beat 32'h0000_0007 -> rdc_tx_par=1; 32'h0000_0003 -> 0; async reset mid-sweep
//   -> all outputs 0 immediately.

Source files
------------

// File: rtl/qf_rfm_pkg.sv
// Shared types and constants for the FCB register-file memory read sequencer.
// Holds the sequencer state encoding and the beat-per-word helpers.
package qf_rfm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } rfm_rd_state_e;

    // Index width for a beat counter; a single-beat word still needs one bit.
    function automatic int rfm_idx_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    localparam int RFM_BEATS_PER_WORD = 64 / 32;
    localparam int RFM_BEAT_IDX_W     = rfm_idx_w(RFM_BEATS_PER_WORD);

endpackage

// File: rtl/qf_rfm_beat_mux.sv
// Word buffer and beat selector for the register-file read stream.
// Ports: clk/rst_n, load (capture word_in), idx (beat select), beat (selected
// slice, beat 0 = least-significant). With QL_RFM_RD_PARITY_EN: par = ^beat.
module qf_rfm_beat_mux #(
    parameter int W     = 64,
    parameter int B     = 32,
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     word_in,
    input  logic [IDX_W-1:0] idx,
    output logic [B-1:0]     beat
`ifdef QL_RFM_RD_PARITY_EN
    ,
    output logic             par
`endif
);

    localparam int BEATS = W / B;

    logic [BEATS-1:0][B-1:0] word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else if (load) begin
            word_q <= word_in;
        end
    end

    assign beat = word_q[idx];

`ifdef QL_RFM_RD_PARITY_EN
    // Derived from registered data, so it moves exactly with the beat.
    assign par = ^beat;
`endif

endmodule

// File: rtl/qf_rfm_rd_seq.sv
// Read-side sequencer for the FCB register-file memory: sweeps rfm_rd_addr over
// a programmed range and streams each word as beats on a valid/ready port.
// Ports: fcb_sys_clk/fcb_sys_rst_n; rdc_start/rdc_start_addr/rdc_word_cnt
// command; rdc_abort; rdc_busy/rdc_done status; rfm_rd_addr/rfm_rd_data memory
// port; rdc_tx_data/valid/ready/last stream. Option QL_RFM_RD_PARITY_EN adds
// rdc_tx_par (even parity of rdc_tx_data).
module qf_rfm_rd_seq
    import qf_rfm_pkg::*;
#(
    parameter int PAR_MEMORY_WIDTH_BIT = 64,
    parameter int PAR_MEMORY_DEPTH_BIT = 4,
    parameter int PAR_BEAT_WIDTH_BIT   = 32
) (
    input  logic                            fcb_sys_clk,
    input  logic                            fcb_sys_rst_n,
    input  logic                            rdc_start,
    input  logic [PAR_MEMORY_DEPTH_BIT-1:0] rdc_start_addr,
    input  logic [PAR_MEMORY_DEPTH_BIT:0]   rdc_word_cnt,
    input  logic                            rdc_abort,
    output logic                            rdc_busy,
    output logic                            rdc_done,
    output logic [PAR_MEMORY_DEPTH_BIT-1:0] rfm_rd_addr,
    input  logic [PAR_MEMORY_WIDTH_BIT-1:0] rfm_rd_data,
    output logic [PAR_BEAT_WIDTH_BIT-1:0]   rdc_tx_data,
    output logic                            rdc_tx_valid,
    input  logic                            rdc_tx_ready,
    output logic                            rdc_tx_last
`ifdef QL_RFM_RD_PARITY_EN
    ,
    output logic                            rdc_tx_par
`endif
);

    localparam int D        = PAR_MEMORY_DEPTH_BIT;
    localparam int BEATS    = PAR_MEMORY_WIDTH_BIT / PAR_BEAT_WIDTH_BIT;
    localparam int IDX_W    = rfm_idx_w(BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    if (PAR_MEMORY_WIDTH_BIT % PAR_BEAT_WIDTH_BIT != 0) begin : g_width_chk
        $error("PAR_MEMORY_WIDTH_BIT must be a multiple of PAR_BEAT_WIDTH_BIT");
    end

    rfm_rd_state_e    state, state_nxt;
    logic [D:0]       remaining;
    logic [IDX_W-1:0] idx;
    logic             start_acc;
    logic             load;
    logic             beat_hs;
    logic             word_end;

    always_ff @(posedge fcb_sys_clk or negedge fcb_sys_rst_n) begin
        if (!fcb_sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort wins over everything, including a start arriving in IDLE.
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        load      = 1'b0;
        beat_hs   = 1'b0;
        word_end  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rdc_start && !rdc_abort) begin
                    start_acc = 1'b1;
                    state_nxt = (rdc_word_cnt != '0) ? FETCH : DONE;
                end
            end
            FETCH: begin
                load      = !rdc_abort;
                state_nxt = SEND;
            end
            SEND: begin
                beat_hs  = rdc_tx_ready && !rdc_abort;
                word_end = beat_hs && (idx == LAST_IDX);
                if (word_end) begin
                    state_nxt = (remaining > (D+1)'(1)) ? FETCH : DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (rdc_abort) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge fcb_sys_clk or negedge fcb_sys_rst_n) begin
        if (!fcb_sys_rst_n) begin
            rfm_rd_addr <= '0;
            remaining   <= '0;
            idx         <= '0;
        end else begin
            if (start_acc) begin
                rfm_rd_addr <= rdc_start_addr;
                remaining   <= rdc_word_cnt;
            end
            if (load) begin
                idx <= '0;
            end else if (beat_hs && !word_end) begin
                idx <= idx + 1'b1;
            end
            // Address advances after every word, wrapping naturally.
            if (word_end) begin
                remaining   <= remaining - 1'b1;
                rfm_rd_addr <= rfm_rd_addr + 1'b1;
            end
        end
    end

    assign rdc_busy     = (state != IDLE);
    assign rdc_done     = (state == DONE);
    assign rdc_tx_valid = (state == SEND);
    assign rdc_tx_last  = rdc_tx_valid && (remaining == (D+1)'(1))
                          && (idx == LAST_IDX);

    qf_rfm_beat_mux #(
        .W     (PAR_MEMORY_WIDTH_BIT),
        .B     (PAR_BEAT_WIDTH_BIT),
        .IDX_W (IDX_W)
    ) u_beat_mux (
        .clk     (fcb_sys_clk),
        .rst_n   (fcb_sys_rst_n),
        .load    (load),
        .word_in (rfm_rd_data),
        .idx     (idx),
        .beat    (rdc_tx_data)
`ifdef QL_RFM_RD_PARITY_EN
        ,
        .par     (rdc_tx_par)
`endif
    );

endmodule

// File: tb/tb_qf_rfm_rd_seq.sv
// Directed scoreboard bench for qf_rfm_rd_seq.
// Expected beats are queued when a sweep starts and checked as the stream drains.
module tb_qf_rfm_rd_seq;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        rdc_start;
    logic [3:0]  rdc_start_addr;
    logic [4:0]  rdc_word_cnt;
    logic        rdc_abort;
    logic        rdc_busy;
    logic        rdc_done;
    logic [3:0]  rfm_rd_addr;
    logic [63:0] rfm_rd_data;
    logic [31:0] rdc_tx_data;
    logic        rdc_tx_valid;
    logic        rdc_tx_ready;
    logic        rdc_tx_last;
`ifdef QL_RFM_RD_PARITY_EN
    logic        rdc_tx_par;
`endif

    logic [63:0] mem [16];
    beat_t       q[$];
    int          vectors;
    int          miscompares;
    int          hs_cnt;
    int          last_cnt;
    int          done_cnt;

    assign rfm_rd_data = mem[rfm_rd_addr];

    qf_rfm_rd_seq dut (
        .fcb_sys_clk    (clk),
        .fcb_sys_rst_n  (rst_n),
        .rdc_start      (rdc_start),
        .rdc_start_addr (rdc_start_addr),
        .rdc_word_cnt   (rdc_word_cnt),
        .rdc_abort      (rdc_abort),
        .rdc_busy       (rdc_busy),
        .rdc_done       (rdc_done),
        .rfm_rd_addr    (rfm_rd_addr),
        .rfm_rd_data    (rfm_rd_data),
        .rdc_tx_data    (rdc_tx_data),
        .rdc_tx_valid   (rdc_tx_valid),
        .rdc_tx_ready   (rdc_tx_ready),
        .rdc_tx_last    (rdc_tx_last)
`ifdef QL_RFM_RD_PARITY_EN
        ,
        .rdc_tx_par     (rdc_tx_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sweep(input logic [3:0] addr, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            logic [3:0]  a;
            logic [63:0] w;
            a = addr + 4'(i);
            w = mem[a];
            q.push_back('{w[31:0], 1'b0});
            q.push_back('{w[63:32], i == cnt - 1});
        end
    endtask

    task automatic start(input logic [3:0] addr, input logic [4:0] cnt);
        rdc_start      = 1'b1;
        rdc_start_addr = addr;
        rdc_word_cnt   = cnt;
        tick();
        rdc_start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rnd) rdc_tx_ready = 1'($urandom_range(0, 1));
            tick();
            if (rdc_done) begin
                seen = 1'b1;
                break;
            end
        end
        rdc_tx_ready = 1'b1;
        chk("done_timeout", 64'(seen), 64'd1);
    endtask

    task automatic clr_counts();
        hs_cnt   = 0;
        last_cnt = 0;
        done_cnt = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rdc_tx_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    chk("beat_data", 64'(rdc_tx_data), 64'(q[0].data));
                    chk("beat_last", 64'(rdc_tx_last), 64'(q[0].last));
`ifdef QL_RFM_RD_PARITY_EN
                    chk("beat_par", 64'(rdc_tx_par), 64'(^q[0].data));
`endif
                    if (rdc_tx_ready) begin
                        if (q[0].last) last_cnt++;
                        void'(q.pop_front());
                        hs_cnt++;
                    end
                end
            end else begin
                chk("last_without_valid", 64'(rdc_tx_last), 64'd0);
            end
            if (rdc_done) done_cnt++;
        end
    end

    initial begin
        vectors        = 0;
        miscompares    = 0;
        clr_counts();
        rst_n          = 1'b0;
        rdc_start      = 1'b0;
        rdc_start_addr = '0;
        rdc_word_cnt   = '0;
        rdc_abort      = 1'b0;
        rdc_tx_ready   = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = {2{32'(i)}};
        mem[3] = 64'hAAAA_BBBB_CCCC_DDDD;
        #3;
        chk("rst_busy",  64'(rdc_busy), 64'd0);
        chk("rst_done",  64'(rdc_done), 64'd0);
        chk("rst_addr",  64'(rfm_rd_addr), 64'd0);
        chk("rst_data",  64'(rdc_tx_data), 64'd0);
        chk("rst_valid", 64'(rdc_tx_valid), 64'd0);
        chk("rst_last",  64'(rdc_tx_last), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single word, latency and pulse timing.
        clr_counts();
        push_sweep(4'd3, 1);
        start(4'd3, 5'd1);
        chk("t1_valid_n1", 64'(rdc_tx_valid), 64'd0);
        chk("t1_busy_n1",  64'(rdc_busy), 64'd1);
        chk("t1_addr",     64'(rfm_rd_addr), 64'd3);
        tick();
        chk("t1_valid_n2", 64'(rdc_tx_valid), 64'd1);
        chk("t1_beat0",    64'(rdc_tx_data), 64'h0000_0000_CCCC_DDDD);
        tick();
        chk("t1_beat1",    64'(rdc_tx_data), 64'h0000_0000_AAAA_BBBB);
        chk("t1_last",     64'(rdc_tx_last), 64'd1);
        tick();
        chk("t1_done",     64'(rdc_done), 64'd1);
        chk("t1_valid_off", 64'(rdc_tx_valid), 64'd0);
        tick();
        chk("t1_done_off", 64'(rdc_done), 64'd0);
        chk("t1_busy_off", 64'(rdc_busy), 64'd0);
        chk("t1_beats",    64'(hs_cnt), 64'd2);

        // Wrapping sweep.
        mem[3] = {2{32'd3}};
        clr_counts();
        push_sweep(4'd14, 4);
        start(4'd14, 5'd4);
        wait_done(60, 1'b0);
        tick();
        chk("t2_beats", 64'(hs_cnt), 64'd8);
        chk("t2_lasts", 64'(last_cnt), 64'd1);
        chk("t2_queue", 64'(q.size()), 64'd0);

        // Full sweep under random backpressure.
        for (int i = 0; i < 16; i++) mem[i] = {32'(i) ^ 32'h5A5A_0000,
                                               32'(i * 7) + 32'h100};
        clr_counts();
        push_sweep(4'd9, 16);
        start(4'd9, 5'd16);
        wait_done(600, 1'b1);
        tick();
        chk("t3_beats", 64'(hs_cnt), 64'd32);
        chk("t3_lasts", 64'(last_cnt), 64'd1);
        chk("t3_queue", 64'(q.size()), 64'd0);

        // Zero-length sweep, then start while busy.
        clr_counts();
        start(4'd5, 5'd0);
        chk("t4_done",  64'(rdc_done), 64'd1);
        chk("t4_valid", 64'(rdc_tx_valid), 64'd0);
        tick();
        chk("t4_done_off", 64'(rdc_done), 64'd0);
        chk("t4_busy_off", 64'(rdc_busy), 64'd0);
        clr_counts();
        push_sweep(4'd0, 2);
        start(4'd0, 5'd2);
        tick();
        start(4'd9, 5'd3);
        wait_done(60, 1'b0);
        tick();
        chk("t4_beats", 64'(hs_cnt), 64'd4);
        chk("t4_queue", 64'(q.size()), 64'd0);
        chk("t4_dones", 64'(done_cnt), 64'd1);

        // Abort during the second word of five.
        clr_counts();
        push_sweep(4'd0, 5);
        start(4'd0, 5'd5);
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (hs_cnt == 2 && rdc_tx_valid) begin
                    hit = 1'b1;
                    break;
                end
            end
            chk("t5_reach_word2", 64'(hit), 64'd1);
        end
        rdc_tx_ready = 1'b0;
        rdc_abort    = 1'b1;
        tick();
        rdc_abort    = 1'b0;
        rdc_tx_ready = 1'b1;
        chk("t5_valid", 64'(rdc_tx_valid), 64'd0);
        chk("t5_busy",  64'(rdc_busy), 64'd0);
        chk("t5_last",  64'(rdc_tx_last), 64'd0);
        q.delete();
        tick();
        tick();
        tick();
        chk("t5_no_done", 64'(done_cnt), 64'd0);
        clr_counts();
        push_sweep(4'd7, 2);
        start(4'd7, 5'd2);
        wait_done(60, 1'b0);
        tick();
        chk("t5_beats", 64'(hs_cnt), 64'd4);
        chk("t5_queue", 64'(q.size()), 64'd0);

        // Word rewritten on the negedge of FETCH carries its new value.
        clr_counts();
        mem[2] = 64'h1111_2222_3333_4444;
        start(4'd2, 5'd1);
        @(negedge clk);
        mem[2] = 64'h0000_0007_0000_0003;
        push_sweep(4'd2, 1);
        wait_done(60, 1'b0);
        tick();
        chk("t6_beats", 64'(hs_cnt), 64'd2);
        chk("t6_queue", 64'(q.size()), 64'd0);

`ifdef QL_RFM_RD_PARITY_EN
        mem[4] = 64'h0000_0003_0000_0007;
        push_sweep(4'd4, 1);
        start(4'd4, 5'd1);
        tick();
        chk("par_7", 64'(rdc_tx_par), 64'd1);
        tick();
        chk("par_3", 64'(rdc_tx_par), 64'd0);
        wait_done(20, 1'b0);
`endif

        // Asynchronous reset in the middle of a sweep.
        clr_counts();
        push_sweep(4'd0, 16);
        start(4'd0, 5'd16);
        tick();
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rr_busy",  64'(rdc_busy), 64'd0);
        chk("rr_done",  64'(rdc_done), 64'd0);
        chk("rr_addr",  64'(rfm_rd_addr), 64'd0);
        chk("rr_data",  64'(rdc_tx_data), 64'd0);
        chk("rr_valid", 64'(rdc_tx_valid), 64'd0);
        chk("rr_last",  64'(rdc_tx_last), 64'd0);
`ifdef QL_RFM_RD_PARITY_EN
        chk("rr_par",   64'(rdc_tx_par), 64'd0);
`endif
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("rr_idle_valid", 64'(rdc_tx_valid), 64'd0);
        chk("rr_idle_busy",  64'(rdc_busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
